// File: rtl/strela_config_loader.sv
// Loads CGRA configuration words into a bitstream register, strobes it into the array and gates execution.
// Optional checksum word is enabled by defining STRELA_CONFIG_LOADER_CHECKSUM_EN.
module strela_config_loader #(
    parameter int DATA_WIDTH      = 32,
    parameter int BITSTREAM_WIDTH = 160,
    parameter int ENABLE_CYCLES   = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       load_i,
    input  logic [DATA_WIDTH-1:0]      cfg_word_i,
    input  logic                       cfg_valid_i,
    output logic                       cfg_ready_o,
    input  logic                       exec_start_i,
    input  logic                       exec_stop_i,
    output logic [BITSTREAM_WIDTH-1:0] config_bitstream_o,
    output logic                       bitstream_enable_o,
    output logic                       execute_o,
    output logic                       busy_o,
    output logic                       cfg_loaded_o,
    output logic                       err_o
);
    localparam int NWORDS  = (BITSTREAM_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
`ifdef STRELA_CONFIG_LOADER_CHECKSUM_EN
    localparam int NXFERS  = NWORDS + 1;
`else
    localparam int NXFERS  = NWORDS;
`endif
    localparam int CNT_W   = $clog2(NXFERS + 1);
    localparam int STORE_W = NWORDS * DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, LOAD, ENABLE, EXEC} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         en_cnt_q, en_cnt_d;
    logic               loaded_q, loaded_d;
    logic [STORE_W-1:0] bits_q;
    logic               xfer;
    logic               last_xfer;

    assign xfer      = cfg_valid_i && (state_q == LOAD);
    assign last_xfer = xfer && (cnt_q == CNT_W'(NXFERS - 1));

`ifdef STRELA_CONFIG_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] csum_q, csum_d;
    logic                  err_q, err_d;
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    always_comb begin
        // NOTE: every variable gets its hold value first so no path can infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        en_cnt_d = en_cnt_q;
        loaded_d = loaded_q;
`ifdef STRELA_CONFIG_LOADER_CHECKSUM_EN
        csum_d   = csum_q;
        err_d    = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (load_i) begin
                    state_d  = LOAD;
                    cnt_d    = '0;
                    loaded_d = 1'b0;
`ifdef STRELA_CONFIG_LOADER_CHECKSUM_EN
                    csum_d   = '0;
                    err_d    = 1'b0;
`endif
                end else if (exec_start_i && loaded_q) begin
                    state_d = EXEC;
                end
            end
            LOAD: begin
                if (xfer) begin
                    cnt_d = cnt_q + CNT_W'(1);
`ifdef STRELA_CONFIG_LOADER_CHECKSUM_EN
                    if (cnt_q < CNT_W'(NWORDS)) csum_d = csum_q ^ cfg_word_i;
`endif
                    if (last_xfer) begin
                        en_cnt_d = '0;
                        state_d  = ENABLE;
`ifdef STRELA_CONFIG_LOADER_CHECKSUM_EN
                        // Final word is the checksum itself; a mismatch drops the load without a strobe.
                        if (cfg_word_i != csum_q) begin
                            state_d = IDLE;
                            err_d   = 1'b1;
                        end
`endif
                    end
                end
            end
            ENABLE: begin
                if (en_cnt_q == 4'(ENABLE_CYCLES - 1)) begin
                    state_d  = IDLE;
                    loaded_d = 1'b1;
                end else begin
                    en_cnt_d = en_cnt_q + 4'(1);
                end
            end
            EXEC: begin
                if (exec_stop_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            en_cnt_q <= '0;
            loaded_q <= 1'b0;
`ifdef STRELA_CONFIG_LOADER_CHECKSUM_EN
            csum_q   <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            en_cnt_q <= en_cnt_d;
            loaded_q <= loaded_d;
`ifdef STRELA_CONFIG_LOADER_CHECKSUM_EN
            csum_q   <= csum_d;
            err_q    <= err_d;
`endif
        end
    end

    // Word k lands in slice k; the checksum word never matches a slice index and is not stored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bits_q <= '0;
        end else if (xfer) begin
            for (int k = 0; k < NWORDS; k++) begin
                if (cnt_q == CNT_W'(k)) bits_q[k*DATA_WIDTH +: DATA_WIDTH] <= cfg_word_i;
            end
        end
    end

    assign cfg_ready_o        = (state_q == LOAD);
    assign bitstream_enable_o = (state_q == ENABLE);
    assign execute_o          = (state_q == EXEC);
    assign busy_o             = (state_q != IDLE);
    assign cfg_loaded_o       = loaded_q;
    assign config_bitstream_o = bits_q[BITSTREAM_WIDTH-1:0];

endmodule
